xtea_iter_engine: RTL and testbench

- Iterative XTEA block-cipher engine: the responder side of the core key/data handshake (i_key_en/o_key_ok, i_din_en/o_dout_en, i_flag).
- Computes one XTEA cycle (two Feistel half-rounds) per clock and returns a 64-bit result after a fixed latency.
- Sits behind the cipher wrapper or testbench driver, which loads a 128-bit key, then streams single blocks for encryption or decryption.

---
 rtl/xtea_iter_engine_if.sv | 40 ++++
 rtl/xtea_iter_engine.sv | 136 +++++++++++++
 tb/tb_xtea_iter_engine.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/xtea_iter_engine_if.sv
//------------------------------------------------------------------------------
// xtea_iter_engine_if
// Key/data handshake bundle between a cipher driver and the XTEA engine.
//   i_flag    1 = encrypt, 0 = decrypt (qualified by i_din_en)
//   i_key     128-bit key {k0,k1,k2,k3}
//   i_key_en  key load strobe
//   i_din     64-bit input block {v0,v1}
//   i_din_en  block start strobe
//   o_dout    64-bit result block {v0,v1}
//   o_dout_en one-cycle result-valid pulse
//   o_key_ok  key loaded, blocks may be issued
//   o_busy    block in progress
// Modports: master = driver side, slave = engine side.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface xtea_iter_engine_if;
  logic         i_flag;
  logic [127:0] i_key;
  logic         i_key_en;
  logic [63:0]  i_din;
  logic         i_din_en;
  logic [63:0]  o_dout;
  logic         o_dout_en;
  logic         o_key_ok;
  logic         o_busy;

  modport master (
    output i_flag, i_key, i_key_en, i_din, i_din_en,
    input  o_dout, o_dout_en, o_key_ok, o_busy
  );

  modport slave (
    input  i_flag, i_key, i_key_en, i_din, i_din_en,
    output o_dout, o_dout_en, o_key_ok, o_busy
  );
endinterface

`default_nettype wire

// File: rtl/xtea_iter_engine.sv
//------------------------------------------------------------------------------
// xtea_iter_engine
// Iterative XTEA engine: one full XTEA cycle (two Feistel half-rounds) per
// clock, result after ROUNDS+2 edges.
//   i_clk  rising-edge clock
//   i_rst  asynchronous active-high reset
//   bus    xtea_iter_engine_if.slave (key load, block start, result, status)
// Parameters: ROUNDS (1..63 XTEA cycles per block), DELTA (schedule constant)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module xtea_iter_engine #(
  parameter int          ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  xtea_iter_engine_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Decryption starts from the sum the encryption ends with.
  localparam logic [31:0] DEC_SUM = DELTA * 32'(ROUNDS);
  localparam logic [5:0]  LAST    = 6'(ROUNDS - 1);

  state_t       state;
  logic [127:0] key_reg;
  logic [127:0] run_key;   // key snapshot for the block in flight
  logic [31:0]  v0, v1, sum;
  logic         mode;
  logic [5:0]   count;
  logic [63:0]  dout;
  logic         dout_en, key_ok, busy;

  logic [31:0]  enc_v0, enc_v1, enc_sum;
  logic [31:0]  dec_v0, dec_v1, dec_sum;
  logic [31:0]  nxt_v0, nxt_v1, nxt_sum;

  function automatic logic [31:0] mix(input logic [31:0] x);
    return ((x << 4) ^ (x >> 5)) + x;
  endfunction

  function automatic logic [31:0] kword(input logic [127:0] k, input logic [1:0] idx);
    case (idx)
      2'd0:    kword = k[127:96];
      2'd1:    kword = k[95:64];
      2'd2:    kword = k[63:32];
      default: kword = k[31:0];
    endcase
  endfunction

  always_comb begin
    enc_v0  = v0 + (mix(v1) ^ (sum + kword(run_key, sum[1:0])));
    enc_sum = sum + DELTA;
    enc_v1  = v1 + (mix(enc_v0) ^ (enc_sum + kword(run_key, enc_sum[12:11])));

    dec_v1  = v1 - (mix(v0) ^ (sum + kword(run_key, sum[12:11])));
    dec_sum = sum - DELTA;
    dec_v0  = v0 - (mix(dec_v1) ^ (dec_sum + kword(run_key, dec_sum[1:0])));

    nxt_v0  = mode ? enc_v0  : dec_v0;
    nxt_v1  = mode ? enc_v1  : dec_v1;
    nxt_sum = mode ? enc_sum : dec_sum;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      key_reg <= '0;
      run_key <= '0;
      v0      <= '0;
      v1      <= '0;
      sum     <= '0;
      mode    <= 1'b0;
      count   <= '0;
      dout    <= '0;
      dout_en <= 1'b0;
      key_ok  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      dout_en <= 1'b0;

      // Key loads are only honoured between blocks.
      if (bus.i_key_en && state == IDLE) begin
        key_reg <= bus.i_key;
        key_ok  <= 1'b1;
      end

      case (state)
        IDLE: begin
          // key_ok is the pre-edge value: a simultaneous key load never
          // starts a block on its own, and an already-loaded key is the one
          // snapshotted here.
          if (bus.i_din_en && key_ok) begin
            run_key <= key_reg;
            v0      <= bus.i_din[63:32];
            v1      <= bus.i_din[31:0];
            mode    <= bus.i_flag;
            count   <= '0;
            sum     <= bus.i_flag ? 32'd0 : DEC_SUM;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          v0    <= nxt_v0;
          v1    <= nxt_v1;
          sum   <= nxt_sum;
          count <= count + 6'd1;
          if (count == LAST) state <= DONE;
        end
        DONE: begin
          dout    <= {v0, v1};
          dout_en <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_dout    = dout;
  assign bus.o_dout_en = dout_en;
  assign bus.o_key_ok  = key_ok;
  assign bus.o_busy    = busy;

endmodule

`default_nettype wire

// File: tb/tb_xtea_iter_engine.sv
//------------------------------------------------------------------------------
// tb_xtea_iter_engine
// Scoreboard bench for xtea_iter_engine: stimulus pushes expected result and
// due cycle; a negedge monitor pops and compares on every o_dout_en.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_xtea_iter_engine;

  localparam logic [127:0] KEY  = 128'h78695a4b3c2d1e0ff0e1d2c3b4a59687;
  localparam logic [63:0]  PT   = 64'hf0e1d2c3b4a59687;
  localparam logic [63:0]  CT   = 64'h704b31344744dfab;
  localparam logic [63:0]  ZCT  = 64'hdee9d4d8f7131ed9;
  localparam int           LAT  = 34;  // driver cycle -> dout_en cycle

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xtea_iter_engine_if bus();

  xtea_iter_engine #(.ROUNDS(32), .DELTA(32'h9E3779B9)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every result pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.o_dout_en === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_dout_en: got dout %h at cycle %0d expected no pulse", bus.o_dout, cyc);
      end else begin
        e = sb.pop_front();
        check("dout", bus.o_dout, e.data);
        check("dout_cycle", 64'(cyc), 64'(e.due));
        check("busy_at_done", {63'd0, bus.o_busy}, 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    bus.i_key    = k;
    bus.i_key_en = 1'b1;
    tick();
    bus.i_key_en = 1'b0;
    check("key_ok_after_load", {63'd0, bus.o_key_ok}, 64'd1);
  endtask

  // Drive a one-cycle block strobe; optionally register the expected result.
  task automatic issue(input logic enc, input logic [63:0] din,
                       input logic [63:0] expv, input bit expect_it);
    exp_t e;
    bus.i_flag   = enc;
    bus.i_din    = din;
    bus.i_din_en = 1'b1;
    if (expect_it) begin
      e.data = expv;
      e.due  = cyc + LAT;
      sb.push_back(e);
    end
    tick();
    bus.i_din_en = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) return;
      tick();
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout: got %0d pending results expected 0", name, sb.size());
    sb.delete();
  endtask

  task automatic wait_pulse(input string name);
    for (int i = 0; i < 100; i++) begin
      if (bus.o_dout_en === 1'b1) return;
      tick();
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout: got no dout_en expected pulse", name);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit saw_busy;
    bus.i_flag   = 1'b0;
    bus.i_key    = '0;
    bus.i_key_en = 1'b0;
    bus.i_din    = '0;
    bus.i_din_en = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_dout",    bus.o_dout, 64'd0);
    check("rst_dout_en", {63'd0, bus.o_dout_en}, 64'd0);
    check("rst_key_ok",  {63'd0, bus.o_key_ok}, 64'd0);
    check("rst_busy",    {63'd0, bus.o_busy}, 64'd0);
    rst = 1'b0;
    tick();

    // Data before key: ignored entirely
    issue(1'b1, PT, '0, 1'b0);
    saw_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      saw_busy |= bus.o_busy;
      tick();
    end
    check("nokey_busy", {63'd0, saw_busy}, 64'd0);
    check("nokey_dout", bus.o_dout, 64'd0);

    // Zero-key encrypt with latency check
    load_key(128'd0);
    issue(1'b1, 64'd0, ZCT, 1'b1);
    check("busy_after_start", {63'd0, bus.o_busy}, 64'd1);
    wait_drain("zero_key");

    // Strobes and key load while busy are ignored
    load_key(KEY);
    issue(1'b1, PT, CT, 1'b1);           // sampled at edge T
    repeat (4) tick();
    issue(1'b0, CT, '0, 1'b0);           // strobe at T+5
    repeat (4) tick();
    bus.i_key = 128'd0;                  // key load attempt at T+10
    bus.i_key_en = 1'b1;
    tick();
    bus.i_key_en = 1'b0;
    check("key_ok_midblock", {63'd0, bus.o_key_ok}, 64'd1);
    check("busy_midblock",   {63'd0, bus.o_busy}, 64'd1);
    repeat (9) tick();
    issue(1'b0, 64'd0, '0, 1'b0);        // strobe at T+20
    wait_drain("busy_strobe");
    issue(1'b1, PT, CT, 1'b1);           // original key still in force
    wait_drain("key_kept");

    // Encrypt/decrypt pairs
    for (int p = 0; p < 8; p++) begin
      issue(1'b1, PT, CT, 1'b1);
      wait_drain("pair_enc");
      issue(1'b0, CT, PT, 1'b1);
      wait_drain("pair_dec");
    end

    // Back-to-back: next strobe in each result cycle -> 34-cycle spacing
    issue(1'b1, PT, CT, 1'b1);
    for (int b = 0; b < 3; b++) begin
      wait_pulse("b2b");
      issue(b[0], b[0] ? PT : CT, b[0] ? CT : PT, 1'b1);
    end
    wait_drain("b2b");

    // Reset mid-block
    issue(1'b1, PT, CT, 1'b1);
    repeat (9) tick();
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check("midrst_dout",    bus.o_dout, 64'd0);
    check("midrst_dout_en", {63'd0, bus.o_dout_en}, 64'd0);
    check("midrst_key_ok",  {63'd0, bus.o_key_ok}, 64'd0);
    check("midrst_busy",    {63'd0, bus.o_busy}, 64'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (40) tick();
    check("postrst_key_ok", {63'd0, bus.o_key_ok}, 64'd0);

    // Key and block strobe together with no key: key loads, block does not
    bus.i_key    = 128'd0;
    bus.i_key_en = 1'b1;
    issue(1'b1, 64'd0, '0, 1'b0);
    bus.i_key_en = 1'b0;
    check("both_key_ok", {63'd0, bus.o_key_ok}, 64'd1);
    repeat (3) tick();
    check("both_no_busy", {63'd0, bus.o_busy}, 64'd0);
    issue(1'b1, 64'd0, ZCT, 1'b1);
    wait_drain("post_reset");

    repeat (5) tick();
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
